caxi4interconnect_rdata_slave_arb: RTL and testbench

CAXI4INTERCONNECT_RDATA_SLAVE_ARB -- requirements
Module: caxi4interconnect_rdata_slave_arb

---
 rtl/caxi4interconnect_pkg.sv | 15 +
 rtl/caxi4interconnect_rdata_slave_arb_if.sv | 36 +++
 rtl/caxi4interconnect_rr_select.sv | 31 +++
 rtl/caxi4interconnect_rdata_slave_arb.sv | 119 +++++++++++
 tb/tb_caxi4interconnect_rdata_slave_arb.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/caxi4interconnect_pkg.sv
// Shared AXI4 interconnect definitions.
// Holds the arbiter FSM state encoding and the outstanding-burst limit,
// used by both the read-data and the write-response slave arbiters.
package caxi4interconnect_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Hard ceiling on outstanding bursts; the counter is sized to hold it.
  localparam int OPEN_TRANS_LIMIT = 15;
  localparam int OPEN_CNT_W       = 4;

endpackage

// File: rtl/caxi4interconnect_rdata_slave_arb_if.sv
// Bus bundle for the read-data slave arbiter.
// slave modport  : arbiter side (takes RVALID/RLAST/match per slave, RREADY from
//                  master and read-issue strobe; drives RREADY per slave, RVALID to
//                  master, grant index and outstanding-burst bookkeeping).
// master modport : environment side, the mirror image.
interface caxi4interconnect_rdata_slave_arb_if #(
  parameter int NUM_SLAVES       = 2,
  parameter int NUM_SLAVES_WIDTH = 1
);

  logic [NUM_SLAVES-1:0]       slaveValid;
  logic [NUM_SLAVES-1:0]       slaveMatch;
  logic [NUM_SLAVES-1:0]       slaveLast;
  logic                        masterReady;
  logic                        rdIssue;
  logic [NUM_SLAVES-1:0]       slaveReady;
  logic                        masterValid;
  logic [NUM_SLAVES_WIDTH-1:0] grantIdx;
  logic                        openTransDec;
  logic [3:0]                  openCount;
  logic                        rdFifoFull;
  logic                        errUnderflow;

  modport slave (
    input  slaveValid, slaveMatch, slaveLast, masterReady, rdIssue,
    output slaveReady, masterValid, grantIdx, openTransDec, openCount,
           rdFifoFull, errUnderflow
  );

  modport master (
    output slaveValid, slaveMatch, slaveLast, masterReady, rdIssue,
    input  slaveReady, masterValid, grantIdx, openTransDec, openCount,
           rdFifoFull, errUnderflow
  );

endinterface

// File: rtl/caxi4interconnect_rr_select.sv
// Combinational round-robin search.
// Ports: req (request vector), ptr (highest-priority index) ->
//        winner (first requesting index at or after ptr, wrapping), any (some request).
module caxi4interconnect_rr_select #(
  parameter int NUM_SLAVES       = 2,
  parameter int NUM_SLAVES_WIDTH = 1
) (
  input  logic [NUM_SLAVES-1:0]       req,
  input  logic [NUM_SLAVES_WIDTH-1:0] ptr,
  output logic [NUM_SLAVES_WIDTH-1:0] winner,
  output logic                        any
);

  logic [NUM_SLAVES_WIDTH-1:0] idx;

  // Walk offsets from farthest to nearest so the closest request to ptr
  // is the last one written and therefore wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      idx = NUM_SLAVES_WIDTH'((int'(ptr) + k) % NUM_SLAVES);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/caxi4interconnect_rdata_slave_arb.sv
// Read-data slave arbiter for one AXI4 master port.
// Picks one eligible slave (valid, ID matches this master, connected) by
// round-robin, locks it for a whole burst and passes RVALID/RREADY through
// combinationally. Also tracks outstanding read bursts for the address path.
// Ports: sysClk, sysReset (async, active-low), bus (slave modport: per-slave
//        RVALID/match/RLAST/RREADY, master RVALID/RREADY, grantIdx, rdIssue,
//        openTransDec, openCount, rdFifoFull, errUnderflow).
module caxi4interconnect_rdata_slave_arb
  import caxi4interconnect_pkg::*;
#(
  parameter int                    NUM_SLAVES               = 2,
  parameter int                    NUM_SLAVES_WIDTH         = 1,
  parameter int                    OPEN_RDTRANS_MAX         = 2,
  parameter logic [NUM_SLAVES-1:0] MASTER_READ_CONNECTIVITY = '1
) (
  input  logic                                sysClk,
  input  logic                                sysReset,
  caxi4interconnect_rdata_slave_arb_if.slave  bus
);

  localparam int LIMIT = (OPEN_RDTRANS_MAX > OPEN_TRANS_LIMIT) ? OPEN_TRANS_LIMIT
                                                                : OPEN_RDTRANS_MAX;
  localparam logic [OPEN_CNT_W-1:0] CNT_MAX = OPEN_CNT_W'(LIMIT);

  arb_state_e                  state, state_nxt;
  logic [NUM_SLAVES_WIDTH-1:0] grant_idx, rr_ptr, rr_winner, grant_inc;
  logic [NUM_SLAVES-1:0]       eligible;
  logic                        rr_any, beat_valid, last_beat;
  logic [OPEN_CNT_W-1:0]       open_count;
  logic                        open_trans_dec, err_underflow;

  // Saturating up/down step; simultaneous issue and completion cancel out.
  function automatic logic [OPEN_CNT_W-1:0] count_step(
    input logic [OPEN_CNT_W-1:0] cnt,
    input logic                  inc,
    input logic                  dec
  );
    logic [OPEN_CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec && cnt != CNT_MAX)
      res = cnt + 1'b1;
    else if (dec && !inc && cnt != '0)
      res = cnt - 1'b1;
    return res;
  endfunction

  assign eligible   = bus.slaveValid & bus.slaveMatch & MASTER_READ_CONNECTIVITY;
  assign beat_valid = bus.slaveValid[grant_idx];
  assign last_beat  = (state == ST_BURST) & beat_valid & bus.masterReady
                      & bus.slaveLast[grant_idx];
  assign grant_inc  = (grant_idx == NUM_SLAVES_WIDTH'(NUM_SLAVES - 1))
                      ? '0 : grant_idx + 1'b1;

  caxi4interconnect_rr_select #(
    .NUM_SLAVES       (NUM_SLAVES),
    .NUM_SLAVES_WIDTH (NUM_SLAVES_WIDTH)
  ) u_rr_select (
    .req    (eligible),
    .ptr    (rr_ptr),
    .winner (rr_winner),
    .any    (rr_any)
  );

  always_comb begin
    state_nxt       = state;
    bus.masterValid = 1'b0;
    bus.slaveReady  = '0;
    case (state)
      ST_IDLE: begin
        if (rr_any)
          state_nxt = ST_BURST;
      end
      ST_BURST: begin
        bus.masterValid           = beat_valid;
        bus.slaveReady[grant_idx] = bus.masterReady;
        if (last_beat)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant is captured only in IDLE, so it stays locked for the whole burst.
  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && rr_any)
        grant_idx <= rr_winner;
      if (last_beat)
        rr_ptr <= grant_inc;
    end
  end

  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      open_count     <= '0;
      open_trans_dec <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      open_count     <= count_step(open_count, bus.rdIssue, last_beat);
      open_trans_dec <= last_beat;
      // A completion with nothing outstanding is a protocol error, but the
      // burst itself still finishes normally.
      if (last_beat && open_count == '0)
        err_underflow <= 1'b1;
    end
  end

  assign bus.grantIdx     = grant_idx;
  assign bus.openTransDec = open_trans_dec;
  assign bus.openCount    = open_count;
  assign bus.rdFifoFull   = (open_count == CNT_MAX);
  assign bus.errUnderflow = err_underflow;

endmodule

// File: tb/tb_caxi4interconnect_rdata_slave_arb.sv
// Self-checking bench for caxi4interconnect_rdata_slave_arb.
module tb_caxi4interconnect_rdata_slave_arb;

  logic sysClk;
  logic sysReset;
  int   n_checks = 0;
  int   n_errors = 0;

  caxi4interconnect_rdata_slave_arb_if #(.NUM_SLAVES(2), .NUM_SLAVES_WIDTH(1)) bus_a();
  caxi4interconnect_rdata_slave_arb_if #(.NUM_SLAVES(2), .NUM_SLAVES_WIDTH(1)) bus_b();

  caxi4interconnect_rdata_slave_arb #(
    .NUM_SLAVES(2), .NUM_SLAVES_WIDTH(1), .OPEN_RDTRANS_MAX(2),
    .MASTER_READ_CONNECTIVITY(2'b11)
  ) dut_a (
    .sysClk(sysClk), .sysReset(sysReset), .bus(bus_a)
  );

  caxi4interconnect_rdata_slave_arb #(
    .NUM_SLAVES(2), .NUM_SLAVES_WIDTH(1), .OPEN_RDTRANS_MAX(2),
    .MASTER_READ_CONNECTIVITY(2'b10)
  ) dut_b (
    .sysClk(sysClk), .sysReset(sysReset), .bus(bus_b)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  m;
    int          len;
    logic [15:0] rdy;
    logic [15:0] vld;
    logic        exp_g;
  } burst_t;

  burst_t tbl[9];
  logic   sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at a falling edge with the FSM in IDLE; leaves at a falling edge
  // right after the last beat.
  task automatic run_burst(input burst_t b);
    int   beats;
    int   cyc;
    logic exp_g;
    logic vb;
    logic rb;
    beats = 0;
    cyc   = 0;
    sb_q.push_back(b.exp_g);
    bus_a.slaveValid  = b.v;
    bus_a.slaveMatch  = b.m;
    bus_a.slaveLast   = 2'b00;
    bus_a.masterReady = 1'b1;
    bus_a.rdIssue     = 1'b0;
    #1;
    check("bubble_mvalid", 32'(bus_a.masterValid), 0);
    check("bubble_sready", 32'(bus_a.slaveReady), 0);
    @(posedge sysClk);
    @(negedge sysClk);
    exp_g = sb_q.pop_front();
    while (beats < b.len && cyc < 40) begin
      vb = b.vld[cyc[3:0]];
      rb = b.rdy[cyc[3:0]];
      bus_a.slaveValid  = vb ? b.v : (b.v & ~(2'b01 << exp_g));
      bus_a.masterReady = rb;
      bus_a.slaveLast   = (beats == b.len - 1) ? 2'b11 : 2'b00;
      #1;
      check("grant", 32'(bus_a.grantIdx), 32'(exp_g));
      check("mvalid", 32'(bus_a.masterValid), 32'(vb));
      check("sready", 32'(bus_a.slaveReady), rb ? 32'(2'b01 << exp_g) : 0);
      if (cyc == 0) check("dec_low", 32'(bus_a.openTransDec), 0);
      if (vb && rb) beats++;
      @(posedge sysClk);
      @(negedge sysClk);
      cyc++;
    end
    check("beats", beats, b.len);
    check("dec_pulse", 32'(bus_a.openTransDec), 1);
    check("idle_after", 32'(bus_a.masterValid), 0);
    bus_a.slaveValid = 2'b00;
    bus_a.slaveLast  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b11, 2'b11, 4, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[1] = '{2'b11, 2'b11, 4, 16'hFFFF, 16'hFFFF, 1'b1};
    tbl[2] = '{2'b11, 2'b11, 4, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[3] = '{2'b11, 2'b11, 4, 16'hFFFF, 16'hFFFF, 1'b1};
    tbl[4] = '{2'b11, 2'b11, 3, 16'h5555, 16'hFFFF, 1'b0};
    tbl[5] = '{2'b11, 2'b01, 2, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[6] = '{2'b10, 2'b11, 1, 16'hFFFF, 16'hFFFF, 1'b1};
    tbl[7] = '{2'b11, 2'b11, 3, 16'hFFFF, 16'hFFF9, 1'b0};
    tbl[8] = '{2'b11, 2'b10, 2, 16'hFFFF, 16'hFFFF, 1'b1};

    sysReset          = 1'b1;
    bus_a.slaveValid  = 2'b11;
    bus_a.slaveMatch  = 2'b11;
    bus_a.slaveLast   = 2'b00;
    bus_a.masterReady = 1'b0;
    bus_a.rdIssue     = 1'b0;
    bus_b.slaveValid  = 2'b01;
    bus_b.slaveMatch  = 2'b01;
    bus_b.slaveLast   = 2'b00;
    bus_b.masterReady = 1'b1;
    bus_b.rdIssue     = 1'b0;
    #2 sysReset = 1'b0;

    // Held in reset with both slaves requesting.
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    check("rst_mvalid", 32'(bus_a.masterValid), 0);
    check("rst_sready", 32'(bus_a.slaveReady), 0);
    check("rst_grant", 32'(bus_a.grantIdx), 0);
    check("rst_count", 32'(bus_a.openCount), 0);
    check("rst_dec", 32'(bus_a.openTransDec), 0);
    check("rst_full", 32'(bus_a.rdFifoFull), 0);
    check("rst_err", 32'(bus_a.errUnderflow), 0);
    sysReset = 1'b1;
    @(posedge sysClk);
    @(negedge sysClk);
    check("rel_grant", 32'(bus_a.grantIdx), 0);
    check("rel_mvalid", 32'(bus_a.masterValid), 1);
    @(posedge sysClk);
    @(negedge sysClk);
    check("rel_grant2", 32'(bus_a.grantIdx), 0);
    check("rel_mvalid2", 32'(bus_a.masterValid), 1);

    // Last beat with nothing outstanding.
    bus_a.masterReady = 1'b1;
    bus_a.slaveLast   = 2'b11;
    #1;
    check("uf_sready", 32'(bus_a.slaveReady), 32'h1);
    @(posedge sysClk);
    @(negedge sysClk);
    bus_a.slaveValid = 2'b00;
    bus_a.slaveLast  = 2'b00;
    check("uf_err", 32'(bus_a.errUnderflow), 1);
    check("uf_count", 32'(bus_a.openCount), 0);
    check("uf_dec", 32'(bus_a.openTransDec), 1);
    check("uf_idle", 32'(bus_a.masterValid), 0);
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    check("uf_sticky", 32'(bus_a.errUnderflow), 1);
    check("uf_dec_gone", 32'(bus_a.openTransDec), 0);

    // Reset in the middle of a burst abandons it.
    bus_a.slaveValid  = 2'b01;
    bus_a.masterReady = 1'b0;
    @(posedge sysClk);
    @(negedge sysClk);
    check("mid_mvalid", 32'(bus_a.masterValid), 1);
    bus_a.masterReady = 1'b1;
    bus_a.slaveLast   = 2'b11;
    sysReset = 1'b0;
    #1;
    check("async_mvalid", 32'(bus_a.masterValid), 0);
    check("async_sready", 32'(bus_a.slaveReady), 0);
    check("async_err", 32'(bus_a.errUnderflow), 0);
    bus_a.slaveValid = 2'b00;
    bus_a.slaveLast  = 2'b00;
    @(posedge sysClk);
    @(negedge sysClk);
    sysReset = 1'b1;
    @(posedge sysClk);
    @(negedge sysClk);
    check("abandon_dec", 32'(bus_a.openTransDec), 0);
    check("abandon_mvalid", 32'(bus_a.masterValid), 0);

    // Round-robin, backpressure and valid-drop bursts.
    for (int i = 0; i < 9; i++) run_burst(tbl[i]);
    check("sb_empty", 32'(sb_q.size()), 0);

    // Outstanding-burst counter.
    sysReset = 1'b0;
    @(posedge sysClk);
    @(negedge sysClk);
    sysReset = 1'b1;
    bus_a.rdIssue = 1'b1;
    @(posedge sysClk);
    @(negedge sysClk);
    check("cnt_1", 32'(bus_a.openCount), 1);
    check("full_1", 32'(bus_a.rdFifoFull), 0);
    @(posedge sysClk);
    @(negedge sysClk);
    check("cnt_2", 32'(bus_a.openCount), 2);
    check("full_2", 32'(bus_a.rdFifoFull), 1);
    @(posedge sysClk);
    @(negedge sysClk);
    check("cnt_sat", 32'(bus_a.openCount), 2);
    check("full_sat", 32'(bus_a.rdFifoFull), 1);
    bus_a.rdIssue     = 1'b0;
    bus_a.slaveValid  = 2'b01;
    bus_a.slaveMatch  = 2'b01;
    bus_a.masterReady = 1'b1;
    @(posedge sysClk);
    @(negedge sysClk);
    bus_a.slaveLast = 2'b11;
    bus_a.rdIssue   = 1'b1;
    @(posedge sysClk);
    @(negedge sysClk);
    bus_a.rdIssue   = 1'b0;
    bus_a.slaveLast = 2'b00;
    check("coinc_cnt", 32'(bus_a.openCount), 2);
    check("coinc_dec", 32'(bus_a.openTransDec), 1);
    check("coinc_err", 32'(bus_a.errUnderflow), 0);
    @(posedge sysClk);
    @(negedge sysClk);
    bus_a.slaveLast = 2'b11;
    @(posedge sysClk);
    @(negedge sysClk);
    bus_a.slaveValid = 2'b00;
    bus_a.slaveLast  = 2'b00;
    check("dec_cnt", 32'(bus_a.openCount), 1);
    check("dec_full", 32'(bus_a.rdFifoFull), 0);
    check("dec_err", 32'(bus_a.errUnderflow), 0);

    // Slave 0 is not connected on dut_b: it must never be served.
    for (int c = 0; c < 20; c++) begin
      @(posedge sysClk);
      @(negedge sysClk);
      check("conn_mvalid", 32'(bus_b.masterValid), 0);
      check("conn_sready", 32'(bus_b.slaveReady), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
